// File: rtl/mine_sequencer_if.sv
// Hash-core handshake bus between the mining sequencer (master) and the shared SHA-256 core (slave).
interface mine_sequencer_if #(
    parameter int HASH_W = 256
) ();
    logic [1:0]        hash_select;
    logic              hash_start;
    logic              hash_done;
    logic [HASH_W-1:0] hash_out;

    modport master (
        output hash_select,
        output hash_start,
        input  hash_done,
        input  hash_out
    );

    modport slave (
        input  hash_select,
        input  hash_start,
        output hash_done,
        output hash_out
    );
endinterface

// File: rtl/mine_sequencer.sv
// Drives the shared SHA-256 core through midstate, per-nonce block hash and rehash,
// then compares the double hash against the difficulty target.
module mine_sequencer #(
    parameter int NONCE_W     = 32,
    parameter int HASH_W      = 256,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               new_block,
    input  logic [HASH_W-1:0]  difficulty,
    input  logic               stop,
    input  logic               result_ack,
    mine_sequencer_if.master   hash_bus,
    output logic               increment,
    output logic [NONCE_W-1:0] nonce,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic               busy
);

    localparam int WDOG_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // The start cycle counts toward the budget, so the wait states stop two short of it.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 2);

    localparam logic [1:0] SEL_MID = 2'd0;
    localparam logic [1:0] SEL_BLK = 2'd1;
    localparam logic [1:0] SEL_DBL = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_MID      = 4'd1,
        S_WAIT_MID = 4'd2,
        S_BLK      = 4'd3,
        S_WAIT_BLK = 4'd4,
        S_DBL      = 4'd5,
        S_WAIT_DBL = 4'd6,
        S_CMP      = 4'd7,
        S_FOUND    = 4'd8,
        S_EXH      = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    state_t            state_r;
    logic [HASH_W-1:0] target_r;
    logic [HASH_W-1:0] digest_r;
    logic [WDOG_W-1:0] wdog_r;

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r              <= S_IDLE;
            hash_bus.hash_select <= SEL_MID;
            hash_bus.hash_start  <= 1'b0;
            increment            <= 1'b0;
            nonce                <= '0;
            found                <= 1'b0;
            exhausted            <= 1'b0;
            timeout_err          <= 1'b0;
            busy                 <= 1'b0;
            target_r             <= '0;
            digest_r             <= '0;
            wdog_r               <= '0;
        end else begin
            hash_bus.hash_start <= 1'b0;
            increment           <= 1'b0;
            if (stop) begin
                state_r     <= S_IDLE;
                found       <= 1'b0;
                exhausted   <= 1'b0;
                timeout_err <= 1'b0;
                busy        <= 1'b0;
            end else if (new_block) begin
                state_r              <= S_MID;
                target_r             <= difficulty;
                nonce                <= '0;
                hash_bus.hash_select <= SEL_MID;
                hash_bus.hash_start  <= 1'b1;
                found                <= 1'b0;
                exhausted            <= 1'b0;
                timeout_err          <= 1'b0;
                busy                 <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r <= S_IDLE;
                    end
                    S_MID: begin
                        state_r <= S_WAIT_MID;
                        wdog_r  <= '0;
                    end
                    S_BLK: begin
                        state_r <= S_WAIT_BLK;
                        wdog_r  <= '0;
                    end
                    S_DBL: begin
                        state_r <= S_WAIT_DBL;
                        wdog_r  <= '0;
                    end
                    S_WAIT_MID, S_WAIT_BLK, S_WAIT_DBL: begin
                        if (hash_bus.hash_done) begin
                            if (state_r == S_WAIT_MID) begin
                                state_r              <= S_BLK;
                                hash_bus.hash_select <= SEL_BLK;
                                hash_bus.hash_start  <= 1'b1;
                            end else if (state_r == S_WAIT_BLK) begin
                                state_r              <= S_DBL;
                                hash_bus.hash_select <= SEL_DBL;
                                hash_bus.hash_start  <= 1'b1;
                            end else begin
                                state_r  <= S_CMP;
                                digest_r <= hash_bus.hash_out;
                            end
                        end else if (wdog_r == WDOG_LAST) begin
                            state_r     <= S_ERR;
                            timeout_err <= 1'b1;
                        end else begin
                            wdog_r <= wdog_r + WDOG_W'(1);
                        end
                    end
                    S_CMP: begin
                        if (digest_r <= target_r) begin
                            state_r <= S_FOUND;
                            found   <= 1'b1;
                        end else if (nonce == {NONCE_W{1'b1}}) begin
                            state_r   <= S_EXH;
                            exhausted <= 1'b1;
                        end else begin
                            state_r              <= S_BLK;
                            nonce                <= nonce + NONCE_W'(1);
                            increment            <= 1'b1;
                            hash_bus.hash_select <= SEL_BLK;
                            hash_bus.hash_start  <= 1'b1;
                        end
                    end
                    S_FOUND, S_EXH, S_ERR: begin
                        if (result_ack) begin
                            state_r     <= S_IDLE;
                            found       <= 1'b0;
                            exhausted   <= 1'b0;
                            timeout_err <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    default: begin
                        state_r     <= S_IDLE;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
